// File: rtl/muldiv4_pkg.sv
// Shared definitions for the 4-bit mul/div datapath: state encoding, default width,
// and a constant-evaluable ceiling log2 for sizing counters.
package muldiv4_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/muldiv4_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor and keep the difference only when it does not borrow.
module muldiv4_div_step
    import muldiv4_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   prem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   prem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             unused_prem_msb;

    // The partial remainder is always below the divisor, so its top bit is never set.
    assign unused_prem_msb = prem[WIDTH];

    always_comb begin
        shifted   = {prem[WIDTH-1:0], next_bit};
        diff      = {1'b0, shifted} - {2'b00, divisor};
        q_bit     = ~diff[WIDTH+1];
        prem_next = q_bit ? diff[WIDTH:0] : shifted;
    end

endmodule

// File: rtl/muldiv4_seq_divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock, registered results,
// divide-by-zero short-cut straight to DONE, one-cycle done pulse.
module muldiv4_seq_divider
    import muldiv4_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned           CNT_W     = clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(WIDTH - 1);

    state_e           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH:0]   prem_next;
    logic             q_bit;

    muldiv4_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .prem      (prem),
        .next_bit  (shift_reg[WIDTH-1]),
        .divisor   (divisor_reg),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            prem        <= '0;
            shift_reg   <= '0;
            divisor_reg <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        divisor_reg <= divisor;
                        shift_reg   <= dividend;
                        prem        <= '0;
                        count       <= '0;
                        busy        <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            state       <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Quotient bits enter at the bottom as dividend bits leave the top.
                    prem      <= prem_next;
                    shift_reg <= {shift_reg[WIDTH-2:0], q_bit};
                    count     <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        quotient  <= {shift_reg[WIDTH-2:0], q_bit};
                        remainder <= prem_next[WIDTH-1:0];
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv4_seq_divider.sv
// Scoreboard bench for the sequential divider: a driver pushes expected results computed
// with plain / and %, and a monitor pops and compares on every done pulse.
module tb_muldiv4_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    muldiv4_seq_divider #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int unsigned  due;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           fails  = 0;
    logic [W-1:0] hold_q = '0;
    logic [W-1:0] hold_r = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: sample just after each rising edge, outside reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst !== 1'b1) begin
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("quotient %0d/%0d", e.a, e.b), quotient, e.q);
                        check($sformatf("remainder %0d/%0d", e.a, e.b), remainder, e.r);
                        check($sformatf("div_by_zero %0d/%0d", e.a, e.b), div_by_zero, e.dbz);
                        check($sformatf("done_cycle %0d/%0d", e.a, e.b), cyc, e.due);
                        check("busy_in_done", busy, 1);
                        hold_q = e.q;
                        hold_r = e.r;
                    end
                end else if (busy) begin
                    // Only nonzero divisors reach RUN; prior results must hold meanwhile.
                    check("hold_quotient", quotient, hold_q);
                    check("hold_remainder", remainder, hold_r);
                    check("dbz_in_run", div_by_zero, 0);
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy,
                         input logic [W-1:0] na, input logic [W-1:0] nb);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            check("idle_wait_timeout", busy, 0);
            return;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.a   = a;
        e.b   = b;
        e.dbz = (b == 0);
        e.q   = (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b));
        e.r   = (b == 0) ? a : W'(int'(a) % int'(b));
        e.due = cyc + 1 + ((b == 0) ? 0 : W);
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        if (noisy) begin
            n        = 0;
            start    = 1'b1;
            dividend = na;
            divisor  = nb;
            while (busy && n < 20) begin
                @(negedge clk);
                start    = 1'($urandom);
                dividend = W'($urandom);
                divisor  = W'($urandom);
                n++;
            end
            start = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_quotient"}, quotient, 0);
        check({tag, "_remainder"}, remainder, 0);
        check({tag, "_div_by_zero"}, div_by_zero, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        issue(4'd13, 4'd3, 1'b0, '0, '0);
        issue(4'd15, 4'd1, 1'b0, '0, '0);
        issue(4'd2, 4'd9, 1'b0, '0, '0);
        issue(4'd7, 4'd0, 1'b0, '0, '0);
        issue(4'd9, 4'd4, 1'b0, '0, '0);
        issue(4'd12, 4'd5, 1'b1, 4'd3, 4'd3);

        // Abort 14/3 mid-RUN with an asynchronous reset.
        issue(4'd14, 4'd3, 1'b0, '0, '0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        sb.delete();
        hold_q = '0;
        hold_r = '0;
        @(negedge clk);
        rst = 1'b0;
        issue(4'd14, 4'd3, 1'b0, '0, '0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(W'(a), W'(b), ($urandom_range(0, 3) == 0), W'($urandom), W'($urandom));
            end
        end

        repeat (60) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), W'($urandom), W'($urandom));
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
